// File: rtl/scan_decoder_n_if.sv
// rtl/scan_decoder_n_if.sv - control inputs and registered line outputs of the scan decoder
interface scan_decoder_n_if #(
    parameter int N = 3
);
    localparam int OUTS = 2 ** N;

    logic            en;
    logic            mode;
    logic [N-1:0]    sel;
    logic [N-1:0]    last;
    logic [OUTS-1:0] y;
    logic [N-1:0]    idx;
    logic            wrap;

    modport master (
        output en, mode, sel, last,
        input  y, idx, wrap
    );

    modport slave (
        input  en, mode, sel, last,
        output y, idx, wrap
    );
endinterface

// File: rtl/scan_decoder_n.sv
// rtl/scan_decoder_n.sv - registered N-to-2^N one-hot decoder with direct and prescaled scan modes
module scan_decoder_n #(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    scan_decoder_n_if.slave  bus
);
    localparam int              OUTS     = 2 ** N;
    localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(DIV - 1);
    localparam logic [OUTS-1:0] INACTIVE = {OUTS{ACTIVE_LOW}};

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic [N-1:0]    idx_next;
    logic [OUTS-1:0] y_next;
    logic            tick;
    logic            at_end;
    logic            wrap_next;

    // idx_next is shared by the idx and y registers so both always name the same line.
    always_comb begin
        tick      = bus.en & bus.mode & (cnt == CNT_MAX);
        at_end    = (bus.idx >= bus.last);
        cnt_next  = cnt;
        idx_next  = bus.idx;
        wrap_next = 1'b0;
        if (bus.en) begin
            if (!bus.mode) begin
                cnt_next = '0;
                idx_next = bus.sel;
            end else if (tick) begin
                cnt_next  = '0;
                idx_next  = at_end ? '0 : bus.idx + 1'b1;
                wrap_next = at_end;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
        y_next = bus.en ? ((OUTS'(1) << idx_next) ^ INACTIVE) : INACTIVE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            bus.idx  <= '0;
            bus.wrap <= 1'b0;
            bus.y    <= INACTIVE;
        end else begin
            cnt      <= cnt_next;
            bus.idx  <= idx_next;
            bus.wrap <= wrap_next;
            bus.y    <= y_next;
        end
    end
endmodule

// File: tb/tb_scan_decoder_n.sv
// tb/tb_scan_decoder_n.sv - randomized and directed checks of three decoder variants against a reference model
module tb_scan_decoder_n;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] sel = '0;
    logic [2:0] last = '0;

    int checks = 0;
    int errors = 0;

    // Instance 0: DIV=4 active-high, 1: DIV=4 active-low, 2: DIV=1 active-high.
    int DIVS [3] = '{4, 4, 1};
    int ALS  [3] = '{0, 1, 0};

    int m_cnt [3];
    int m_idx [3];
    int m_wrap[3];
    int m_on  [3];

    logic [7:0] y_o   [3];
    logic [2:0] idx_o [3];
    logic       wrap_o[3];

    scan_decoder_n_if #(.N(3)) bus0 ();
    scan_decoder_n_if #(.N(3)) bus1 ();
    scan_decoder_n_if #(.N(3)) bus2 ();

    assign bus0.en = en;   assign bus0.mode = mode; assign bus0.sel = sel; assign bus0.last = last;
    assign bus1.en = en;   assign bus1.mode = mode; assign bus1.sel = sel; assign bus1.last = last;
    assign bus2.en = en;   assign bus2.mode = mode; assign bus2.sel = sel; assign bus2.last = last;

    assign y_o[0] = bus0.y; assign idx_o[0] = bus0.idx; assign wrap_o[0] = bus0.wrap;
    assign y_o[1] = bus1.y; assign idx_o[1] = bus1.idx; assign wrap_o[1] = bus1.wrap;
    assign y_o[2] = bus2.y; assign idx_o[2] = bus2.idx; assign wrap_o[2] = bus2.wrap;

    scan_decoder_n #(.N(3), .DIV(4), .ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    scan_decoder_n #(.N(3), .DIV(4), .ACTIVE_LOW(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));
    scan_decoder_n #(.N(3), .DIV(1), .ACTIVE_LOW(1'b0)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_y(input int i);
        logic [7:0] v;
        v = m_on[i] ? (8'h01 << m_idx[i]) : 8'h00;
        return (ALS[i] != 0) ? ~v : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_idx[i] = 0; m_wrap[i] = 0; m_on[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            m_wrap[i] = 0;
            if (!en) begin
                m_on[i] = 0;
            end else if (!mode) begin
                m_on[i]  = 1;
                m_cnt[i] = 0;
                m_idx[i] = int'(sel);
            end else begin
                m_on[i] = 1;
                if (m_cnt[i] == DIVS[i] - 1) begin
                    m_cnt[i]  = 0;
                    m_wrap[i] = (m_idx[i] >= int'(last)) ? 1 : 0;
                    m_idx[i]  = (m_idx[i] >= int'(last)) ? 0 : m_idx[i] + 1;
                end else begin
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.y%0d", tag, i),    32'(y_o[i]),   32'(exp_y(i)));
            chk($sformatf("%s.idx%0d", tag, i),  32'(idx_o[i]), 32'(m_idx[i]));
            chk($sformatf("%s.wrap%0d", tag, i), 32'(wrap_o[i]), 32'(m_wrap[i]));
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    // Reset is asserted away from any edge so outputs must clear without a clock.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] onehot;
        int         wraps;
        int         held;

        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk("reset.y0", 32'(bus0.y), 32'h00);
        chk("reset.y1", 32'(bus1.y), 32'hFF);

        // Direct sweep
        en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            cycle("direct");
            onehot = 8'h01 << s;
            chk("direct.y_const", 32'(bus0.y), 32'(onehot));
            chk("direct.wrap_const", 32'(bus0.wrap), 32'h0);
            cycle("direct_hold");
        end

        // Enable gating
        held = int'(bus0.idx);
        en = 1'b0; sel = 3'd2;
        cycle("en_off");
        chk("en_off.y0", 32'(bus0.y), 32'h00);
        chk("en_off.y1", 32'(bus1.y), 32'hFF);
        chk("en_off.idx_held", 32'(bus0.idx), 32'(held));
        en = 1'b1; sel = 3'd5;
        cycle("en_on");
        chk("en_on.y0", 32'(bus0.y), 32'h20);
        chk("en_on.y1", 32'(bus1.y), 32'hDF);

        // Full scan, last=7: wrap once per 32 clocks on the DIV=4 instance
        do_reset();
        mode = 1'b1; last = 3'd7;
        wraps = 0;
        for (int c = 0; c < 64; c++) begin
            cycle("scan7");
            if (bus0.wrap) wraps++;
        end
        chk("scan7.wrap_count", 32'(wraps), 32'd2);
        chk("scan7.idx_end", 32'(bus0.idx), 32'd0);

        // Short scan, then last lowered below idx
        do_reset();
        last = 3'd2;
        for (int c = 0; c < 8; c++) cycle("scan2");
        chk("scan2.idx_at2", 32'(bus0.idx), 32'd2);
        last = 3'd1;
        for (int c = 0; c < 4; c++) cycle("lower_last");
        chk("lower_last.idx", 32'(bus0.idx), 32'd0);
        chk("lower_last.wrap", 32'(bus0.wrap), 32'd1);
        for (int c = 0; c < 12; c++) cycle("scan1");
        last = 3'd0;
        wraps = 0;
        for (int c = 0; c < 16; c++) begin
            cycle("scan0");
            if (bus0.wrap) wraps++;
        end
        chk("scan0.idx", 32'(bus0.idx), 32'd0);
        chk("scan0.wrap_count", 32'(wraps), 32'd4);

        // Reset mid-scan at idx=5, then first step DIV clocks after release
        do_reset();
        last = 3'd7;
        for (int c = 0; c < 20; c++) cycle("to5");
        chk("to5.idx", 32'(bus0.idx), 32'd5);
        do_reset();
        chk("midreset.y0", 32'(bus0.y), 32'h00);
        chk("midreset.idx0", 32'(bus0.idx), 32'd0);
        for (int c = 0; c < 3; c++) cycle("post_reset");
        chk("post_reset.idx_still0", 32'(bus0.idx), 32'd0);
        cycle("post_reset");
        chk("post_reset.idx1", 32'(bus0.idx), 32'd1);

        // Mode switch at idx=3
        for (int c = 0; c < 8; c++) cycle("to3");
        chk("to3.idx", 32'(bus0.idx), 32'd3);
        mode = 1'b0; sel = 3'd6;
        cycle("to_direct");
        chk("to_direct.idx", 32'(bus0.idx), 32'd6);
        chk("to_direct.y", 32'(bus0.y), 32'h40);
        mode = 1'b1;
        for (int c = 0; c < 4; c++) cycle("to_scan");
        chk("to_scan.idx", 32'(bus0.idx), 32'd7);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            en = ($urandom_range(0, 9) != 0);
            sel = 3'($urandom);
            if ($urandom_range(0, 15) == 0) last = 3'($urandom);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
